jtopl_pg_seq: RTL
=================

Name: jtopl_pg_seq

Overview:
- Time-multiplexed phase-generator sequencer for the OPL operator slots.
- Steps a slot counter on each clock enable and holds per-slot frequency config (fnum, block, mul), phase accumulators and key-on state.
- Feeds one shared jtopl_pg_sum instance per slot visit and writes the new phase back.
- Emits the 10-bit operator phase with its slot tag to the operator/envelope stage.

Parameters:
- SLOTS, 18, number of operator slots visited per round (9 channels x 2 operators).
- SW, 5, slot index width; must satisfy 2^SW >= SLOTS.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cen  input  1  clock enable; all state advances only when cen=1.
- cfg_we  input  1  config write strobe, sampled when cen=1.
- cfg_slot  input  SW  slot addressed by the config write.
- cfg_fnum  input  10  F-number.
- cfg_block  input  3  octave block.
- cfg_mul  input  4  multiplier code.
- kon_we  input  1  key-on write strobe, sampled when cen=1.
- kon_slot  input  SW  slot addressed by the key-on write.
- kon  input  1  new key-on level.
- op_slot  output  SW  slot tag of op_phase.
- op_phase  output  10  phase_op for op_slot.
- op_valid  output  1  op_slot/op_phase updated this cen.
- zero  output  1  high during the cen cycle in which op_slot=0 is presented.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of cen):
  - slot counter=0; all phases, fnum, block, mul and kon bits = 0; all pending-reset flags cleared.
  - op_slot=0, op_phase=0, op_valid=0, zero=0.
  - Reset mid-round aborts the round; the first visit after reset is slot 0.
- cen=0: no state changes; outputs hold.
- Slot counter:
  - Increments on each cen; wraps SLOTS-1 -> 0. Never takes a value >= SLOTS.
- Stage 0 (cen edge with counter=s): register the following for slot s:
  - phase_in = phase[s] (19 bits), mul[s], pend[s];
  - phinc_pure = ({7'b0,fnum[s]} << block[s]), truncated to 17 bits (max fnum=0x3FF, block=7 -> 0x1FF80, no loss).
- Stage 1 (next cen edge):
  - jtopl_pg_sum combinationally computes phase_out = pg_rst ? 0 : phase_in + (phinc_pure*factor[mul])[19:1], mod 2^19, where pg_rst is the registered pend value.
  - phase[s] <= phase_out; pend[s] <= 0 (unless re-set this cycle, see below).
  - op_phase <= phase_out[18:9]; op_slot <= s; op_valid <= 1; zero <= (s==0).
- Latency: exactly 2 cen cycles from counter=s to op_slot=s at the output; throughput one slot per cen.
- op_valid:
  - Low until the first stage-1 completes after reset.
  - Then high on every cen cycle; held otherwise.
- Config writes:
  - cfg_we with cfg_slot >= SLOTS is ignored.
  - A write lands on a cen edge. If that slot is in stage 0 on the same edge, the old value is used this visit and the new value on the next visit.
- Key-on:
  - kon_we stores kon[kon_slot]. A 0->1 transition sets pend[kon_slot]. 1->1 and 1->0 do not set it.
  - kon_slot >= SLOTS is ignored.
  - Set wins over clear: a set and a stage-1 clear of the same slot on the same edge leave pend=1, and the reset applies on the next visit.
  - A pending reset forces phase to 0 on the slot's next stage 1, and op_phase=0 for that visit.
- Phase wrap: a 19-bit sum overflow wraps silently; no flag.

Test Plan:
- Reset check: hold rst 3 cycles with cen=1 -> all outputs 0; first op_valid two cens after rst drops, with op_slot=0, zero=1.
- Accumulation: slot 5 fnum=0x200, block=4, mul=1 (factor 2) -> increment 0x2000 per visit. op_phase for slot 5 reads 16, 32, 48 … on successive rounds; after 64 visits the phase wraps and op_phase=0.
- Key-on: slot 5 running, kon_we kon=1 -> the next slot-5 output has op_phase=0, then 16 on the following round. A second kon=1 (already on) causes no reset.
- Set-vs-clear race: issue kon 0->1 for slot 3 on the same cen edge as slot 3's stage 1 -> that visit is unaffected; the following visit outputs op_phase=0.
- Config race: write mul=15 (factor 30) to slot 7 on the edge where slot 7 is in stage 0 -> that visit uses the old mul; the next visit adds (phinc*30)>>1.
- cen gating / sequence: cen toggled 1-in-4 -> op_slot steps 0..17 and wraps to 0, with zero pulses only at slot 0. Config/kon writes for slot 18..31 have no effect.

Source files
------------

// File: rtl/jtopl_pg_seq.sv
// jtopl_pg_seq: time-multiplexed OPL phase-generator sequencer with a shared phase adder
module jtopl_pg_sum (
  input  logic [3:0]  i_mul,
  input  logic [18:0] i_phase_in,
  input  logic        i_pg_rst,
  input  logic [16:0] i_phinc_pure,
  output logic [18:0] o_phase_out
);
  localparam logic [4:0] FAC [0:15] = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14,
                                        5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30};
  logic [21:0] w_prod;
  // multiplier factors are stored doubled so mul=0 (x0.5) stays integer; drop the extra bit after the product
  always_comb begin
    w_prod = 22'(i_phinc_pure) * 22'(FAC[i_mul]);
    o_phase_out = i_pg_rst ? 19'd0 : i_phase_in + w_prod[19:1];
  end
endmodule

module jtopl_pg_seq #(
  parameter int SLOTS = 18,
  parameter int SW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_slot,
  input  logic [9:0]    cfg_fnum,
  input  logic [2:0]    cfg_block,
  input  logic [3:0]    cfg_mul,
  input  logic          kon_we,
  input  logic [SW-1:0] kon_slot,
  input  logic          kon,
  output logic [SW-1:0] op_slot,
  output logic [9:0]    op_phase,
  output logic          op_valid,
  output logic          zero
);
  localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);
  logic [SW-1:0]    r_cnt;
  logic [18:0]      r_phase [SLOTS];
  logic [9:0]       r_fnum  [SLOTS];
  logic [2:0]       r_block [SLOTS];
  logic [3:0]       r_mul   [SLOTS];
  logic [SLOTS-1:0] r_kon;
  logic [SLOTS-1:0] r_pend;
  logic             r_v0;
  logic [SW-1:0]    r_s1;
  logic [18:0]      r_ph_in;
  logic [16:0]      r_phinc;
  logic [3:0]       r_mul1;
  logic             r_pend1;
  logic [16:0]      w_phinc;
  logic [18:0]      w_phase_out;

  assign w_phinc = {7'b0, r_fnum[r_cnt]} << r_block[r_cnt];

  jtopl_pg_sum u_sum (
    .i_mul        (r_mul1),
    .i_phase_in   (r_ph_in),
    .i_pg_rst     (r_pend1),
    .i_phinc_pure (r_phinc),
    .o_phase_out  (w_phase_out)
  );

  // two-stage slot pipeline; key-on set is written last so it beats the stage-1 clear of the same slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_kon    <= '0;
      r_pend   <= '0;
      r_v0     <= 1'b0;
      r_s1     <= '0;
      r_ph_in  <= '0;
      r_phinc  <= '0;
      r_mul1   <= '0;
      r_pend1  <= 1'b0;
      op_slot  <= '0;
      op_phase <= '0;
      op_valid <= 1'b0;
      zero     <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        r_phase[i] <= '0;
        r_fnum[i]  <= '0;
        r_block[i] <= '0;
        r_mul[i]   <= '0;
      end
    end else if (cen) begin
      r_cnt   <= r_cnt == LAST ? '0 : r_cnt + 1'b1;
      r_v0    <= 1'b1;
      r_s1    <= r_cnt;
      r_ph_in <= r_phase[r_cnt];
      r_phinc <= w_phinc;
      r_mul1  <= r_mul[r_cnt];
      r_pend1 <= r_pend[r_cnt];
      if (r_v0) begin
        r_phase[r_s1] <= w_phase_out;
        r_pend[r_s1]  <= 1'b0;
        op_phase      <= w_phase_out[18:9];
        op_slot       <= r_s1;
        op_valid      <= 1'b1;
        zero          <= r_s1 == '0;
      end
      if (cfg_we && cfg_slot <= LAST) begin
        r_fnum[cfg_slot]  <= cfg_fnum;
        r_block[cfg_slot] <= cfg_block;
        r_mul[cfg_slot]   <= cfg_mul;
      end
      if (kon_we && kon_slot <= LAST) begin
        r_kon[kon_slot] <= kon;
        if (kon && !r_kon[kon_slot]) r_pend[kon_slot] <= 1'b1;
      end
    end
  end
endmodule
